// File: rtl/adma_pkg.sv
// Shared definitions for the DMA data mover: AXI response encodings,
// default block parameters and the response-severity merge helper.
package adma_pkg;

    // AXI RRESP encodings; numerically ordered by severity
    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    localparam int unsigned ATX_LEN_W_DEF      = 8;
    localparam int unsigned ATX_SRC_DATA_W_DEF = 256;
    localparam int unsigned ATX_NUM_OSTD_DEF   = 4;

    // Worst of two responses: the encoding is ordered so the larger value wins
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] worst;
        if (a > b) begin
            worst = a;
        end else begin
            worst = b;
        end
        return worst;
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// Full-registered skid buffer: both the forward path (data/valid) and the
// backward path (ready) come straight from flops. Holds at most two entries.
module skid_buffer #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);

    logic [DATA_WIDTH-1:0] main_data_r;
    logic                  main_vld_r;
    logic [DATA_WIDTH-1:0] skid_data_r;
    logic                  in_rdy_r;

    // Main/skid register update; in_rdy_r low means the skid slot is occupied
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data_r <= '0;
            main_vld_r  <= 1'b0;
            skid_data_r <= '0;
            in_rdy_r    <= 1'b1;
        end else if (in_rdy_r) begin
            if (!main_vld_r || m_ready) begin
                // Output slot free or draining: input goes straight to output
                main_data_r <= s_data;
                main_vld_r  <= s_valid;
            end else if (s_valid) begin
                // Output stalled: park the accepted beat in the skid slot
                skid_data_r <= s_data;
                in_rdy_r    <= 1'b0;
            end
        end else begin
            if (m_ready) begin
                // Output drained: promote the parked beat, reopen input
                main_data_r <= skid_data_r;
                main_vld_r  <= 1'b1;
                in_rdy_r    <= 1'b1;
            end
        end
    end

    assign s_ready = in_rdy_r;
    assign m_data  = main_data_r;
    assign m_valid = main_vld_r;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO. The head entry is visible on rd_data whenever the FIFO
// is non-empty; rd_en advances to the next entry. Writes when full and reads
// when empty are ignored.
module sync_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         rd_ptr_r;
    logic                  do_wr_s;
    logic                  do_rd_s;

    // Pointers carry one wrap bit so full and empty are distinguishable
    assign empty   = (wr_ptr_r == rd_ptr_r);
    assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_wr_s = wr_en && !full;
    assign do_rd_s = rd_en && !empty;
    assign rd_data = mem_r[rd_ptr_r[AW-1:0]];

    // Storage and pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (do_wr_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
                wr_ptr_r                <= wr_ptr_r + PW'(1);
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
        end
    end

endmodule

// File: rtl/adma_dm_axi_r.sv
// AXI R-channel receiver of the DMA data mover. Registers incoming beats in a
// skid buffer, forwards them to the source data buffer only while a burst
// length is outstanding, counts beats against that length, flags RLAST
// disagreement and reports per-burst completion with the worst response.
module adma_dm_axi_r
    import adma_pkg::*;
#(
    parameter int unsigned ATX_LEN_W      = ATX_LEN_W_DEF,
    parameter int unsigned ATX_SRC_DATA_W = ATX_SRC_DATA_W_DEF,
    parameter int unsigned ATX_NUM_OSTD   = ATX_NUM_OSTD_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ATX_LEN_W-1:0]      atx_arlen,
    input  logic                      atx_vld,
    output logic                      atx_rdy,
    output logic [ATX_SRC_DATA_W-1:0] atx_rdata,
    output logic                      atx_rdata_vld,
    input  logic                      atx_rdata_rdy,
    output logic                      atx_done,
    output logic [1:0]                atx_resp,
    output logic                      atx_last_err,
    input  logic [ATX_SRC_DATA_W-1:0] m_rdata_i,
    input  logic [1:0]                m_rresp_i,
    input  logic                      m_rlast_i,
    input  logic                      m_rvalid_i,
    output logic                      m_rready_o
);

    localparam int unsigned SKID_W = ATX_SRC_DATA_W + 3;

    logic [SKID_W-1:0]         sk_in_s;
    logic [SKID_W-1:0]         sk_out_s;
    logic                      sk_vld_s;
    logic                      sk_rdy_s;
    logic [ATX_SRC_DATA_W-1:0] beat_data_s;
    logic [1:0]                beat_resp_s;
    logic                      beat_last_s;

    logic                      fifo_full_s;
    logic                      fifo_empty_s;
    logic [ATX_LEN_W-1:0]      head_len_s;
    logic                      len_avail_s;
    logic                      push_s;
    logic                      pop_s;

    logic                      db_hsk_s;
    logic                      exp_last_s;
    logic [1:0]                burst_resp_s;

    logic [ATX_LEN_W-1:0]      beat_cnt_r;
    logic [1:0]                resp_acc_r;
    logic                      done_r;
    logic [1:0]                resp_r;
    logic                      last_err_r;

    // R channel payload packed as {rdata, rresp, rlast}
    assign sk_in_s = {m_rdata_i, m_rresp_i, m_rlast_i};

    skid_buffer #(
        .DATA_WIDTH (SKID_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_data  (sk_in_s),
        .s_valid (m_rvalid_i),
        .s_ready (m_rready_o),
        .m_data  (sk_out_s),
        .m_valid (sk_vld_s),
        .m_ready (sk_rdy_s)
    );

    assign beat_data_s = sk_out_s[SKID_W-1:3];
    assign beat_resp_s = sk_out_s[2:1];
    assign beat_last_s = sk_out_s[0];

    sync_fifo #(
        .DATA_WIDTH (ATX_LEN_W),
        .DEPTH      (ATX_NUM_OSTD)
    ) u_len_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push_s),
        .wr_data (atx_arlen),
        .full    (fifo_full_s),
        .rd_en   (pop_s),
        .rd_data (head_len_s),
        .empty   (fifo_empty_s)
    );

    // A full FIFO refuses pushes even if the head pops in the same cycle
    assign atx_rdy     = !fifo_full_s;
    assign push_s      = atx_vld && !fifo_full_s;
    assign len_avail_s = !fifo_empty_s;

    // Beats with no outstanding length stay in the skid buffer (backpressure)
    assign sk_rdy_s      = len_avail_s && atx_rdata_rdy;
    assign db_hsk_s      = sk_vld_s && sk_rdy_s;
    assign atx_rdata     = beat_data_s;
    assign atx_rdata_vld = sk_vld_s && len_avail_s;

    // The burst boundary comes from the beat count, never from RLAST
    assign exp_last_s   = (beat_cnt_r == head_len_s);
    assign pop_s        = db_hsk_s && exp_last_s;
    assign burst_resp_s = resp_max(resp_acc_r, beat_resp_s);

    // Beat counter within the current burst
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_r <= '0;
        end else if (db_hsk_s) begin
            if (exp_last_s) begin
                beat_cnt_r <= '0;
            end else begin
                beat_cnt_r <= beat_cnt_r + ATX_LEN_W'(1);
            end
        end
    end

    // Worst response seen so far in the current burst
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_acc_r <= RESP_OKAY;
        end else if (db_hsk_s) begin
            if (exp_last_s) begin
                resp_acc_r <= RESP_OKAY;
            end else begin
                resp_acc_r <= burst_resp_s;
            end
        end
    end

    // Completion pulse and burst response, one cycle after the last beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_r <= 1'b0;
            resp_r <= RESP_OKAY;
        end else begin
            done_r <= pop_s;
            resp_r <= pop_s ? burst_resp_s : RESP_OKAY;
        end
    end

    // Sticky flag: RLAST disagreed with the expected last beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_err_r <= 1'b0;
        end else if (db_hsk_s && (beat_last_s != exp_last_s)) begin
            last_err_r <= 1'b1;
        end
    end

    assign atx_done     = done_r;
    assign atx_resp     = resp_r;
    assign atx_last_err = last_err_r;

endmodule

// File: tb/tb_adma_dm_axi_r.sv
// Bench for adma_dm_axi_r: a per-cycle vector table for the basic bursts,
// then hand-written sequences for backpressure, FIFO full, random buffer
// stalls and reset in the middle of a burst.
module tb_adma_dm_axi_r;

    localparam int LW = 8;
    localparam int DW = 256;
    localparam int NO = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [LW-1:0] atx_arlen;
    logic          atx_vld;
    logic          atx_rdy;
    logic [DW-1:0] atx_rdata;
    logic          atx_rdata_vld;
    logic          atx_rdata_rdy;
    logic          atx_done;
    logic [1:0]    atx_resp;
    logic          atx_last_err;
    logic [DW-1:0] m_rdata_i;
    logic [1:0]    m_rresp_i;
    logic          m_rlast_i;
    logic          m_rvalid_i;
    logic          m_rready_o;

    always #5 clk = ~clk;

    adma_dm_axi_r #(
        .ATX_LEN_W      (LW),
        .ATX_SRC_DATA_W (DW),
        .ATX_NUM_OSTD   (NO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .atx_arlen     (atx_arlen),
        .atx_vld       (atx_vld),
        .atx_rdy       (atx_rdy),
        .atx_rdata     (atx_rdata),
        .atx_rdata_vld (atx_rdata_vld),
        .atx_rdata_rdy (atx_rdata_rdy),
        .atx_done      (atx_done),
        .atx_resp      (atx_resp),
        .atx_last_err  (atx_last_err),
        .m_rdata_i     (m_rdata_i),
        .m_rresp_i     (m_rresp_i),
        .m_rlast_i     (m_rlast_i),
        .m_rvalid_i    (m_rvalid_i),
        .m_rready_o    (m_rready_o)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One row per clock: inputs driven before the edge, outputs expected after it
    typedef struct {
        logic        av;
        logic [7:0]  alen;
        logic        rv;
        logic [15:0] rd;
        logic [1:0]  rr;
        logic        rl;
        logic        dr;
        logic        e_rrdy;
        logic        e_vld;
        logic [15:0] e_rd;
        logic        e_done;
        logic [1:0]  e_resp;
        logic        e_err;
        logic        e_ardy;
    } vec_t;

    function automatic vec_t mk(input logic av, input logic [7:0] alen, input logic rv,
                                input logic [15:0] rd, input logic [1:0] rr, input logic rl,
                                input logic dr, input logic e_rrdy, input logic e_vld,
                                input logic [15:0] e_rd, input logic e_done,
                                input logic [1:0] e_resp, input logic e_err, input logic e_ardy);
        vec_t v;
        v.av = av; v.alen = alen; v.rv = rv; v.rd = rd; v.rr = rr; v.rl = rl; v.dr = dr;
        v.e_rrdy = e_rrdy; v.e_vld = e_vld; v.e_rd = e_rd; v.e_done = e_done;
        v.e_resp = e_resp; v.e_err = e_err; v.e_ardy = e_ardy;
        return v;
    endfunction

    typedef struct {
        logic [31:0] d;
        logic [1:0]  r;
        logic        l;
    } beat_t;

    vec_t          tbl[$];
    beat_t         bq[$];
    logic [DW-1:0] got_q[$];
    logic [1:0]    done_q[$];

    // Monitor: record beats taken by the data buffer and completion responses
    always @(posedge clk) begin
        if (rst_n) begin
            if (atx_rdata_vld && atx_rdata_rdy) got_q.push_back(atx_rdata);
            if (atx_done) done_q.push_back(atx_resp);
        end
    end

    task automatic idle_inputs();
        atx_vld    = 1'b0;
        atx_arlen  = 8'd0;
        m_rvalid_i = 1'b0;
        m_rdata_i  = '0;
        m_rresp_i  = 2'd0;
        m_rlast_i  = 1'b0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        idle_inputs();
        atx_rdata_rdy = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        chk1({tag, "_rready"},   m_rready_o,    1'b1);
        chk1({tag, "_vld"},      atx_rdata_vld, 1'b0);
        chk1({tag, "_atx_rdy"},  atx_rdy,       1'b1);
        chk1({tag, "_done"},     atx_done,      1'b0);
        chk2({tag, "_resp"},     atx_resp,      2'd0);
        chk1({tag, "_last_err"}, atx_last_err,  1'b0);
    endtask

    // Push one length; call at a negedge
    task automatic push_len(input logic [7:0] len);
        logic ok;
        ok = 1'b0;
        @(negedge clk);
        atx_arlen = len;
        atx_vld   = 1'b1;
        for (int c = 0; c < 200 && !ok; c++) begin
            ok = atx_rdy;
            @(posedge clk);
            if (!ok) @(negedge clk);
        end
        @(negedge clk);
        atx_vld = 1'b0;
        chk1("ar_push_accepted", ok, 1'b1);
    endtask

    // Drive every beat of bq back to back with AXI valid/ready handshakes
    task automatic send_beats();
        logic ok;
        for (int i = 0; i < bq.size(); i++) begin
            ok = 1'b0;
            @(negedge clk);
            m_rvalid_i = 1'b1;
            m_rdata_i  = {8{bq[i].d}};
            m_rresp_i  = bq[i].r;
            m_rlast_i  = bq[i].l;
            for (int c = 0; c < 300 && !ok; c++) begin
                ok = m_rready_o;
                @(posedge clk);
                if (!ok) @(negedge clk);
            end
            chk1($sformatf("r_hsk_beat%0d", i), ok, 1'b1);
        end
        @(negedge clk);
        m_rvalid_i = 1'b0;
    endtask

    task automatic wait_done(input int n, input int bound);
        for (int c = 0; c < bound && done_q.size() < n; c++) @(posedge clk);
        #1;
        chki("done_count", done_q.size(), n);
    endtask

    function automatic beat_t mkb(input logic [31:0] d, input logic [1:0] r, input logic l);
        beat_t b;
        b.d = d; b.r = r; b.l = l;
        return b;
    endfunction

    initial begin
        logic [1:0] exp_resp[4];

        // ---- per-cycle vectors ----
        // ARLEN=3, four beats A0..A3, buffer always ready
        tbl.push_back(mk(1'b1, 8'd3, 1'b1, 16'h00A0, 2'd0, 1'b0, 1'b1,  1'b1, 1'b1, 16'h00A0, 1'b0, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 8'd0, 1'b1, 16'h00A1, 2'd0, 1'b0, 1'b1,  1'b1, 1'b1, 16'h00A1, 1'b0, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 8'd0, 1'b1, 16'h00A2, 2'd0, 1'b0, 1'b1,  1'b1, 1'b1, 16'h00A2, 1'b0, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 8'd0, 1'b1, 16'h00A3, 2'd0, 1'b1, 1'b1,  1'b1, 1'b1, 16'h00A3, 1'b0, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b1,  1'b1, 1'b0, 16'h0000, 1'b1, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b1,  1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b1));
        // lengths 0,1,0 back to back, four beats streamed
        tbl.push_back(mk(1'b1, 8'd0, 1'b1, 16'h00B0, 2'd0, 1'b1, 1'b1,  1'b1, 1'b1, 16'h00B0, 1'b0, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 8'd1, 1'b1, 16'h00B1, 2'd0, 1'b0, 1'b1,  1'b1, 1'b1, 16'h00B1, 1'b1, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 8'd0, 1'b1, 16'h00B2, 2'd0, 1'b1, 1'b1,  1'b1, 1'b1, 16'h00B2, 1'b0, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 8'd0, 1'b1, 16'h00B3, 2'd0, 1'b1, 1'b1,  1'b1, 1'b1, 16'h00B3, 1'b1, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b1,  1'b1, 1'b0, 16'h0000, 1'b1, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b1,  1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b1));
        // ARLEN=2 with OKAY,SLVERR,OKAY then ARLEN=1 with DECERR on beat 0
        tbl.push_back(mk(1'b1, 8'd2, 1'b1, 16'h00C0, 2'd0, 1'b0, 1'b1,  1'b1, 1'b1, 16'h00C0, 1'b0, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 8'd1, 1'b1, 16'h00C1, 2'd2, 1'b0, 1'b1,  1'b1, 1'b1, 16'h00C1, 1'b0, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 8'd0, 1'b1, 16'h00C2, 2'd0, 1'b1, 1'b1,  1'b1, 1'b1, 16'h00C2, 1'b0, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 8'd0, 1'b1, 16'h00D0, 2'd3, 1'b0, 1'b1,  1'b1, 1'b1, 16'h00D0, 1'b1, 2'd2, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 8'd0, 1'b1, 16'h00D1, 2'd0, 1'b1, 1'b1,  1'b1, 1'b1, 16'h00D1, 1'b0, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b1,  1'b1, 1'b0, 16'h0000, 1'b1, 2'd3, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b1,  1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b1));
        // ARLEN=1 with RLAST on beat 0: sticky error, burst still two beats
        tbl.push_back(mk(1'b1, 8'd1, 1'b1, 16'h00E0, 2'd0, 1'b1, 1'b1,  1'b1, 1'b1, 16'h00E0, 1'b0, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 8'd0, 1'b1, 16'h00E1, 2'd0, 1'b1, 1'b1,  1'b1, 1'b1, 16'h00E1, 1'b0, 2'd0, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b1,  1'b1, 1'b0, 16'h0000, 1'b1, 2'd0, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b1,  1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b1, 1'b1));
        // ARLEN=1 with the data buffer stalled: skid fills, RREADY drops
        tbl.push_back(mk(1'b1, 8'd1, 1'b1, 16'h0050, 2'd0, 1'b0, 1'b0,  1'b1, 1'b1, 16'h0050, 1'b0, 2'd0, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 8'd0, 1'b1, 16'h0051, 2'd0, 1'b1, 1'b0,  1'b0, 1'b1, 16'h0050, 1'b0, 2'd0, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0,  1'b0, 1'b1, 16'h0050, 1'b0, 2'd0, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b1,  1'b1, 1'b1, 16'h0051, 1'b0, 2'd0, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b1,  1'b1, 1'b0, 16'h0000, 1'b1, 2'd0, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b1,  1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b1, 1'b1));

        reset_dut();
        #1;
        check_reset_values("reset");

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            atx_vld       = tbl[i].av;
            atx_arlen     = tbl[i].alen;
            m_rvalid_i    = tbl[i].rv;
            m_rdata_i     = {16{tbl[i].rd}};
            m_rresp_i     = tbl[i].rr;
            m_rlast_i     = tbl[i].rl;
            atx_rdata_rdy = tbl[i].dr;
            @(posedge clk);
            #1;
            chk1($sformatf("v%0d_rready", i),   m_rready_o,    tbl[i].e_rrdy);
            chk1($sformatf("v%0d_vld", i),      atx_rdata_vld, tbl[i].e_vld);
            chk1($sformatf("v%0d_done", i),     atx_done,      tbl[i].e_done);
            chk1($sformatf("v%0d_last_err", i), atx_last_err,  tbl[i].e_err);
            chk1($sformatf("v%0d_atx_rdy", i),  atx_rdy,       tbl[i].e_ardy);
            if (tbl[i].e_vld) chkd($sformatf("v%0d_rdata", i), atx_rdata, {16{tbl[i].e_rd}});
            if (tbl[i].e_done) chk2($sformatf("v%0d_resp", i), atx_resp, tbl[i].e_resp);
        end
        @(negedge clk);
        idle_inputs();

        // ---- beats with no outstanding length are held, then drained ----
        reset_dut();
        got_q.delete();
        done_q.delete();
        bq.delete();
        for (int i = 0; i < 3; i++) bq.push_back(mkb(32'hF000_0000 + 32'(i), 2'd0, (i == 2)));
        fork
            send_beats();
            begin
                repeat (6) @(negedge clk);
                chk1("hold_rready_low", m_rready_o, 1'b0);
                chk1("hold_no_vld", atx_rdata_vld, 1'b0);
                chki("hold_nothing_out", got_q.size(), 0);
                push_len(8'd2);
            end
        join
        wait_done(1, 20);
        chki("hold_beats_out", got_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chkd($sformatf("hold_beat%0d", i), (got_q.size() > i) ? got_q[i] : '0,
                 {8{32'hF000_0000 + 32'(i)}});
        end
        chk2("hold_resp", (done_q.size() > 0) ? done_q[0] : 2'bxx, 2'd0);
        chk1("hold_rready_back", m_rready_o, 1'b1);

        // ---- fill the length FIFO, then drain with random buffer stalls ----
        @(negedge clk);
        atx_rdata_rdy = 1'b0;
        push_len(8'd1);
        push_len(8'd0);
        push_len(8'd2);
        push_len(8'd1);
        chk1("full_atx_rdy_low", atx_rdy, 1'b0);
        atx_arlen = 8'd5;
        atx_vld   = 1'b1;
        repeat (3) @(negedge clk);
        atx_vld = 1'b0;
        chk1("full_still_full", atx_rdy, 1'b0);

        got_q.delete();
        done_q.delete();
        bq.delete();
        bq.push_back(mkb(32'h6000_0000, 2'd1, 1'b0));
        bq.push_back(mkb(32'h6000_0001, 2'd0, 1'b1));
        bq.push_back(mkb(32'h6000_0002, 2'd2, 1'b1));
        bq.push_back(mkb(32'h6000_0003, 2'd0, 1'b0));
        bq.push_back(mkb(32'h6000_0004, 2'd3, 1'b0));
        bq.push_back(mkb(32'h6000_0005, 2'd1, 1'b1));
        bq.push_back(mkb(32'h6000_0006, 2'd0, 1'b0));
        bq.push_back(mkb(32'h6000_0007, 2'd0, 1'b1));
        exp_resp[0] = 2'd1;
        exp_resp[1] = 2'd2;
        exp_resp[2] = 2'd3;
        exp_resp[3] = 2'd0;
        fork
            send_beats();
            begin
                for (int c = 0; c < 600 && done_q.size() < 4; c++) begin
                    @(negedge clk);
                    atx_rdata_rdy = 1'($urandom_range(0, 1));
                end
                atx_rdata_rdy = 1'b1;
            end
        join
        wait_done(4, 50);
        chki("rand_beats_out", got_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chkd($sformatf("rand_beat%0d", i), (got_q.size() > i) ? got_q[i] : '0,
                 {8{32'h6000_0000 + 32'(i)}});
        end
        for (int i = 0; i < 4; i++) begin
            chk2($sformatf("rand_resp%0d", i), (done_q.size() > i) ? done_q[i] : 2'bxx, exp_resp[i]);
        end
        chk1("rand_no_last_err", atx_last_err, 1'b0);
        chk1("rand_fifo_empty", atx_rdy, 1'b1);

        // a refused push must not have left a length behind: an extra beat stays held
        bq.delete();
        bq.push_back(mkb(32'h7777_0000, 2'd0, 1'b1));
        send_beats();
        repeat (3) @(negedge clk);
        chk1("orphan_not_forwarded", atx_rdata_vld, 1'b0);
        chki("orphan_count", got_q.size(), 8);

        // ---- reset in the middle of a burst ----
        reset_dut();
        got_q.delete();
        done_q.delete();
        push_len(8'd3);
        bq.delete();
        bq.push_back(mkb(32'h4800_0000, 2'd2, 1'b1));
        bq.push_back(mkb(32'h4800_0001, 2'd0, 1'b0));
        send_beats();
        repeat (2) @(negedge clk);
        chk1("mid_err_set", atx_last_err, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        got_q.delete();
        done_q.delete();
        push_len(8'd0);
        bq.delete();
        bq.push_back(mkb(32'h4B00_0000, 2'd2, 1'b1));
        send_beats();
        wait_done(1, 20);
        chkd("post_reset_beat", (got_q.size() > 0) ? got_q[0] : '0, {8{32'h4B00_0000}});
        chk2("post_reset_resp", (done_q.size() > 0) ? done_q[0] : 2'bxx, 2'd2);
        chk1("post_reset_no_err", atx_last_err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
